// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared fetch-stage types and constants
// Purpose: enums for the fetch FSM and the EX-stage PC control encodings,
//          datapath width selection and the canonical NOP word.
// Ports:   none (package).
package fetch_pc_unit_pkg;

`ifdef BIT_COUNT_64
  localparam int XLEN_DEF = 64;
`else
  localparam int XLEN_DEF = 32;
`endif

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetchState;

  typedef enum logic [1:0] {
    PCp4_I   = 2'd0,
    Jump_R   = 2'd1,
    Jump_C   = 2'd2,
    Branch_C = 2'd3
  } pcSrc_e;

  typedef enum logic [2:0] {
    NO_BRANCH = 3'd0,
    BEQ       = 3'd1,
    BNE       = 3'd2,
    BLT       = 3'd3,
    BGE       = 3'd4,
    BLTU      = 3'd5,
    BGEU      = 3'd6
  } condSrc_e;

endpackage

// File: rtl/fetch_pc_unit_branch_compare.sv
// rtl/fetch_pc_unit_branch_compare.sv - combinational branch condition evaluator
// Purpose: decides whether a conditional branch in EX is taken.
// Ports:   ex_condSrc (condition select), ex_rs1/ex_rs2 (forwarded operands),
//          taken (condition true; NO_BRANCH and unused codes are never taken).
module fetch_pc_unit_branch_compare
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      ex_condSrc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (condSrc_e'(ex_condSrc))
      BEQ:     taken = (ex_rs1 == ex_rs2);
      BNE:     taken = (ex_rs1 != ex_rs2);
      BLT:     taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      BGE:     taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      BLTU:    taken = (ex_rs1 <  ex_rs2);
      BGEU:    taken = (ex_rs1 >= ex_rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - IF stage: PC ownership, instruction fetch, redirect handling
// Purpose: issues instruction-memory requests at the PC, delivers {instr, pc, pc+4}
//          to IF/ID, resolves EX-stage jumps/branches and redirects the PC.
// Ports:   clk, reset (async, active-high), stall (hold IF/ID and PC);
//          ex_pcSrc/ex_condSrc/ex_rs1/ex_rs2/ex_pcPlusImm/ex_aluAdd (EX control/targets);
//          imem_req/imem_addr out, imem_ready/imem_rdata in (fetch handshake);
//          if_valid/if_instr/if_pc/if_pcPlus4 (IF/ID outputs);
//          flush (squash IF/ID and ID/EX), misaligned (sticky per redirect).
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [1:0]      ex_pcSrc,
  input  logic [2:0]      ex_condSrc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pcPlusImm,
  input  logic [XLEN-1:0] ex_aluAdd,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pcPlus4,
  output logic            flush,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);

  logic            taken;
  logic            redirect;
  logic [XLEN-1:0] target;

  fetchState       state_q, state_d;
  logic            req_en_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     skid_q, skid_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pcp4_q, if_pcp4_d;
  logic            mis_q, mis_d;

  fetch_pc_unit_branch_compare #(.XLEN(XLEN)) u_branch_compare (
    .ex_condSrc (ex_condSrc),
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .taken      (taken)
  );

  always_comb begin
    redirect = (ex_pcSrc == Jump_R) || (ex_pcSrc == Jump_C) ||
               ((ex_pcSrc == Branch_C) && taken);
    target   = (ex_pcSrc == Jump_C) ? (ex_aluAdd & ALIGN_MASK) : ex_pcPlusImm;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_pcp4_d  = if_pcp4_q;
    mis_d      = mis_q;
    imem_req   = 1'b0;

    // Unstalled IF/ID drains to a bubble unless a word is presented below.
    if (!stall) if_valid_d = 1'b0;

    case (state_q)
      FETCH: begin
        // req_en_q keeps the request low for the first cycle out of reset.
        imem_req = req_en_q;
        if (req_en_q && imem_ready) begin
          if (redirect) begin
            // Word belongs to the wrong path; dropped.
          end else if (stall) begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_pcp4_d  = pc_q + PC_STEP;
            pc_d       = pc_q + PC_STEP;
          end
        end else if (req_en_q && redirect) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = FETCH;
        end else if (!stall) begin
          if_valid_d = 1'b1;
          if_instr_d = skid_q;
          if_pc_d    = pc_q;
          if_pcp4_d  = pc_q + PC_STEP;
          pc_d       = pc_q + PC_STEP;
          state_d    = FETCH;
        end
      end
      DROP: begin
        // The PC already holds the latest target, so it doubles as the target latch.
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Redirect wins over stall and over anything captured above.
    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      mis_d      = (target[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      req_en_q   <= 1'b0;
      pc_q       <= RESET_PC;
      skid_q     <= NOP_INSTR;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= RESET_PC;
      if_pcp4_q  <= RESET_PC + PC_STEP;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_en_q   <= 1'b1;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_pcp4_q  <= if_pcp4_d;
      mis_q      <= mis_d;
    end
  end

  assign imem_addr  = pc_q;
  assign if_valid   = if_valid_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign if_pcPlus4 = if_pcp4_q;
  assign flush      = redirect;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  localparam int XL = XLEN_DEF;
  localparam logic [XL-1:0] RPC = XL'(32'h100);

  logic          clk = 1'b0;
  logic          reset, stall;
  logic [1:0]    ex_pcSrc;
  logic [2:0]    ex_condSrc;
  logic [XL-1:0] ex_rs1, ex_rs2, ex_pcPlusImm, ex_aluAdd;
  logic          imem_req, imem_ready;
  logic [XL-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          if_valid, flush, misaligned;
  logic [31:0]   if_instr;
  logic [XL-1:0] if_pc, if_pcPlus4;

  fetch_pc_unit #(.XLEN(XL), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ex_pcSrc(ex_pcSrc), .ex_condSrc(ex_condSrc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pcPlusImm(ex_pcPlusImm), .ex_aluAdd(ex_aluAdd),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pcPlus4(if_pcPlus4),
    .flush(flush), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int beats  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Instruction memory: fixed content per address, latency of mem_lat wait cycles.
  int            mem_lat;
  logic          mem_busy;
  int            mem_cnt;
  logic [XL-1:0] mem_addr_q;

  function automatic logic [31:0] word_at(input logic [XL-1:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  always_comb begin
    imem_ready = (mem_busy || imem_req) && (mem_cnt >= mem_lat);
    imem_rdata = word_at(mem_busy ? mem_addr_q : imem_addr);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
    end else if (imem_ready) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
    end else if (mem_busy || imem_req) begin
      if (!mem_busy) mem_addr_q <= imem_addr;
      mem_busy <= 1'b1;
      mem_cnt  <= mem_cnt + 1;
    end
  end

  // Reference model: the architectural fetch stream is sequential from the last
  // redirect target; the scoreboard holds the PCs IF/ID must hand over, in order.
  logic [XL-1:0] exp_q[$];
  logic [XL-1:0] exp_pc;
  logic          exp_flush, exp_mis, exp_mis_pend;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + XL'(4);
    end
  endtask

  task automatic idle_ex();
    ex_pcSrc = PCp4_I; ex_condSrc = NO_BRANCH;
    ex_rs1 = '0; ex_rs2 = '0; ex_pcPlusImm = '0; ex_aluAdd = '0;
    exp_flush = 1'b0;
  endtask

  task automatic model_reset();
    idle_ex();
    exp_q.delete();
    exp_pc = RPC;
    exp_mis = 1'b0;
    exp_mis_pend = 1'b0;
    refill();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_ex();
    exp_mis = exp_mis_pend;
    refill();
  endtask

  task automatic drive_ex(input logic [1:0] src, input logic [2:0] cond,
                          input logic [XL-1:0] a, input logic [XL-1:0] b,
                          input logic [XL-1:0] imm, input logic [XL-1:0] alu);
    logic tk, rd;
    logic [XL-1:0] tgt;
    ex_pcSrc = src; ex_condSrc = cond; ex_rs1 = a; ex_rs2 = b;
    ex_pcPlusImm = imm; ex_aluAdd = alu;
    case (condSrc_e'(cond))
      BEQ:     tk = (a == b);
      BNE:     tk = (a != b);
      BLT:     tk = ($signed(a) <  $signed(b));
      BGE:     tk = ($signed(a) >= $signed(b));
      BLTU:    tk = (a <  b);
      BGEU:    tk = (a >= b);
      default: tk = 1'b0;
    endcase
    rd  = (src == Jump_R) || (src == Jump_C) || ((src == Branch_C) && tk);
    tgt = (src == Jump_C) ? {alu[XL-1:1], 1'b0} : imm;
    exp_flush = rd;
    if (rd) begin
      exp_q.delete();
      exp_pc = tgt;
      exp_mis_pend = (tgt[1:0] != 2'b00);
      refill();
    end
  endtask

  // Monitor: a beat is handed to decode when valid, not stalled and not squashed.
  logic [XL-1:0] mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      check("flush", 64'(flush), 64'(exp_flush));
      check("misaligned", 64'(misaligned), 64'(exp_mis));
      if (if_valid && !stall && !flush) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("if_pc", 64'(if_pc), 64'(mon_e));
          check("if_instr", 64'(if_instr), 64'(word_at(mon_e)));
          check("if_pcPlus4", 64'(if_pcPlus4), 64'(mon_e + XL'(4)));
          beats++;
        end
      end
    end
  end

  task automatic wait_fresh_req();
    int k = 0;
    while (!(imem_req && !mem_busy) && k < 20) begin step(); k++; end
    check("fresh_req_seen", 64'(imem_req && !mem_busy), 64'd1);
  endtask

  logic [XL-1:0] rs_tab[5];
  logic [XL-1:0] hold_addr, hold_pc;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rs_tab[0] = '0; rs_tab[1] = XL'(1); rs_tab[2] = '1; rs_tab[3] = XL'(5);
    rs_tab[4] = {1'b1, {(XL-1){1'b0}}};
    reset = 1'b1; stall = 1'b0; mem_lat = 0;
    model_reset();

    // Reset state
    step();
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'(NOP_INSTR));
    check("rst_if_pc", 64'(if_pc), 64'(RPC));
    check("rst_if_pcPlus4", 64'(if_pcPlus4), 64'(RPC + XL'(4)));
    check("rst_imem_addr", 64'(imem_addr), 64'(RPC));
    check("rst_misaligned", 64'(misaligned), 64'd0);
    step();
    reset = 1'b0;
    check("first_cycle_no_req", 64'(imem_req), 64'd0);

    // Sequential fetch with zero-wait memory
    step();
    check("req_cycle1", 64'(imem_req), 64'd1);
    check("addr_cycle1", 64'(imem_addr), 64'h100);
    step();
    check("addr_cycle2", 64'(imem_addr), 64'h104);
    check("valid_cycle2", 64'(if_valid), 64'd1);
    check("if_pc_cycle2", 64'(if_pc), 64'h100);
    step();
    check("addr_cycle3", 64'(imem_addr), 64'h108);

    // BEQ taken / not taken
    drive_ex(Branch_C, BEQ, XL'(5), XL'(5), XL'(32'h200), '0);
    step();
    check("beq_target", 64'(imem_addr), 64'h200);
    drive_ex(Branch_C, BEQ, XL'(5), XL'(6), XL'(32'h280), '0);
    step();
    check("beq_nt_seq", 64'(imem_addr), 64'h204);

    // Signed vs unsigned less-than
    drive_ex(Branch_C, BLT, '1, XL'(1), XL'(32'h240), '0);
    step();
    check("blt_target", 64'(imem_addr), 64'h240);
    drive_ex(Branch_C, BLTU, '1, XL'(1), XL'(32'h2C0), '0);
    step();
    check("bltu_nt_seq", 64'(imem_addr), 64'h244);

    // JALR clears bit 0; bit 1 set flags misaligned
    drive_ex(Jump_C, NO_BRANCH, '0, '0, '0, XL'(32'h305));
    step();
    check("jalr_target", 64'(imem_addr), 64'h304);
    check("jalr_aligned", 64'(misaligned), 64'd0);
    drive_ex(Jump_R, NO_BRANCH, '0, '0, XL'(32'h302), '0);
    step();
    check("mis_target", 64'(imem_addr), 64'h302);
    check("mis_flag", 64'(misaligned), 64'd1);

    // Three-cycle stall with memory ready
    drive_ex(Jump_R, NO_BRANCH, '0, '0, XL'(32'h500), '0);
    step();
    step();
    stall = 1'b1;
    hold_addr = imem_addr;
    hold_pc = if_pc;
    check("stall_pc_start", 64'(hold_pc), 64'h500);
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_addr_frozen", 64'(imem_addr), 64'(hold_addr));
      check("stall_if_pc_frozen", 64'(if_pc), 64'(hold_pc));
      check("stall_if_valid", 64'(if_valid), 64'd1);
      if (k == 0) check("hold_no_req", 64'(imem_req), 64'd0);
    end
    step();
    stall = 1'b0;
    repeat (4) step();

    // Slow memory, redirect during the wait
    mem_lat = 3;
    wait_fresh_req();
    step();
    drive_ex(Jump_R, NO_BRANCH, '0, '0, XL'(32'h400), '0);
    begin
      int k = 0;
      step();
      while (!if_valid && k < 30) begin step(); k++; end
      check("drop_next_pc", 64'(if_pc), 64'h400);
    end

    // Reset while a dropped request is outstanding
    wait_fresh_req();
    step();
    drive_ex(Jump_R, NO_BRANCH, '0, '0, XL'(32'h600), '0);
    step();
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_if_valid", 64'(if_valid), 64'd0);
    check("midrst_pc", 64'(imem_addr), 64'(RPC));
    step();
    step();
    reset = 1'b0;
    repeat (20) step();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i % 64 == 0) mem_lat = $urandom_range(0, 3);
      if (i == 1500) begin
        reset = 1'b1;
        model_reset();
        step();
        step();
        reset = 1'b0;
      end else begin
        int r;
        stall = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 19);
        if (r >= 16) begin
          logic [1:0] src;
          src = (r == 16) ? Jump_R : (r == 17) ? Jump_C : Branch_C;
          drive_ex(src, 3'($urandom_range(0, 7)),
                   rs_tab[$urandom_range(0, 4)], rs_tab[$urandom_range(0, 4)],
                   XL'(32'h1000 + 4 * $urandom_range(0, 255) + (($urandom_range(0, 7) == 0) ? 2 : 0)),
                   XL'(32'h2000 + $urandom_range(0, 1023)));
        end
      end
    end
    stall = 1'b0;
    mem_lat = 0;
    repeat (20) step();
    check("beats_consumed_min", 64'(beats >= 200), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
